// File: rtl/bit_skip_pkg.sv
// Shared types and widths for the zero-skipping bit-serial scheduler.
package bit_skip_pkg;
  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 5;

  typedef enum logic {IDLE, SCAN} sched_state_t;
  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t bit_rev(input word_t w);
    word_t r;
    for (int i = 0; i < WORD_W; i++) r[i] = w[WORD_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/lead_one_enc_16.sv
// Leading-one encoder: zero-based index of the highest set bit plus a found flag.
module lead_one_enc_16
  import bit_skip_pkg::*;
(
  input  word_t            in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Ascending scan, so the last hit is the highest set bit.
    for (int i = 0; i < WORD_W; i++) begin
      if (in_vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bit_skip_sched_16.sv
// Zero-skipping bit-plane scheduler: one beat per set bit of each accepted word.
// Optional saturating statistics counters enabled by BIT_SKIP_SCHED_STAT_EN.
module bit_skip_sched_16
  import bit_skip_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              out_zero,
  output logic [4:0]        out_cnt,
  output logic              busy,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_beats
);
  sched_state_t     state_q, state_d;
  word_t            residue_q, residue_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_meta_q, rst_ok_q;

  word_t            enc_in, idx_mask;
  logic [IDX_W-1:0] enc_idx, beat_idx;
  logic             enc_found, scan, beat_fire, accept;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_ok_q   <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_ok_q   <= rst_meta_q;
    end
  end

  assign enc_in = MSB_FIRST ? residue_q : bit_rev(residue_q);

  lead_one_enc_16 u_enc (
    .in_vec (enc_in),
    .idx    (enc_idx),
    .found  (enc_found)
  );

  // Reversed encoding maps back to the true bit position; empty residue reports 0.
  assign beat_idx = !enc_found ? '0 :
                    (MSB_FIRST ? enc_idx : IDX_W'(WORD_W-1) - enc_idx);
  assign idx_mask = word_t'(1) << beat_idx;

  assign scan      = rst_ok_q && (state_q == SCAN);
  assign out_valid = scan;
  assign out_idx   = scan ? beat_idx : '0;
  assign out_last  = scan && (zero_q || ((residue_q & ~idx_mask) == '0));
  assign out_zero  = scan && zero_q;
  assign out_cnt   = cnt_q;
  assign busy      = (state_q != IDLE);
  assign in_ready  = rst_ok_q && ((state_q == IDLE) || (out_last && out_ready));
  assign beat_fire = scan && out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    zero_d    = zero_q;
    cnt_d     = cnt_q;
    if (beat_fire) begin
      residue_d = residue_q & ~idx_mask;
      cnt_d     = cnt_q + CNT_W'(1);
      if (out_last) begin
        state_d = IDLE;
        zero_d  = 1'b0;
        cnt_d   = '0;
      end
    end
    // A new word can load on the same edge that retires the last beat.
    if (accept) begin
      state_d   = SCAN;
      residue_d = in_data;
      zero_d    = (in_data == '0);
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      residue_q <= '0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      zero_q    <= zero_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BIT_SKIP_SCHED_STAT_EN
  logic [STAT_W-1:0] words_q, words_d, beats_q, beats_d;

  always_comb begin
    words_d = words_q;
    beats_d = beats_q;
    if (accept && !(&words_q))                beats_d = beats_q;
    if (accept && !(&words_q))                words_d = words_q + STAT_W'(1);
    if (beat_fire && !zero_q && !(&beats_q))  beats_d = beats_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      beats_q <= '0;
    end else begin
      words_q <= words_d;
      beats_q <= beats_d;
    end
  end

  assign stat_words = words_q;
  assign stat_beats = beats_q;
`else
  assign stat_words = '0;
  assign stat_beats = '0;
`endif
endmodule

// File: tb/tb_bit_skip_sched_16.sv
// Directed bench for bit_skip_sched_16: beat table plus stall, back-to-back,
// LSB-first and mid-word reset sequences.
module tb_bit_skip_sched_16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, out_zero, busy;
  logic [15:0] in_data;
  logic [3:0]  out_idx;
  logic [4:0]  out_cnt;
  logic [31:0] stat_words, stat_beats;

  logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_last, l_out_zero, l_busy;
  logic [15:0] l_in_data;
  logic [3:0]  l_out_idx;
  logic [4:0]  l_out_cnt;
  logic [31:0] l_stat_words, l_stat_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_skip_sched_16 #(.MSB_FIRST(1'b1), .STAT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .out_zero(out_zero), .out_cnt(out_cnt), .busy(busy),
    .stat_words(stat_words), .stat_beats(stat_beats)
  );

  bit_skip_sched_16 #(.MSB_FIRST(1'b0), .STAT_W(32)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_idx(l_out_idx), .out_last(l_out_last),
    .out_zero(l_out_zero), .out_cnt(l_out_cnt), .busy(l_busy),
    .stat_words(l_stat_words), .stat_beats(l_stat_beats)
  );

  typedef struct {
    logic [15:0] data;
    logic        new_word;
    logic [3:0]  idx;
    logic        last;
    logic        zero;
    logic [4:0]  cnt;
  } beat_vec_t;

  beat_vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] idx, input logic last,
                          input logic zero, input logic [4:0] cnt);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_idx"},   32'(out_idx),   32'(idx));
    chk({tag, " out_last"},  32'(out_last),  32'(last));
    chk({tag, " out_zero"},  32'(out_zero),  32'(zero));
    chk({tag, " out_cnt"},   32'(out_cnt),   32'(cnt));
    chk({tag, " busy"},      32'(busy),      32'd1);
  endtask

  initial begin
    int exp_words, exp_beats;
    exp_words = 0;
    exp_beats = 0;
    tbl[0] = '{16'h8005, 1'b1, 4'd15, 1'b0, 1'b0, 5'd0};
    tbl[1] = '{16'h8005, 1'b0, 4'd2,  1'b0, 1'b0, 5'd1};
    tbl[2] = '{16'h8005, 1'b0, 4'd0,  1'b1, 1'b0, 5'd2};
    tbl[3] = '{16'h0000, 1'b1, 4'd0,  1'b1, 1'b1, 5'd0};
    tbl[4] = '{16'h0120, 1'b1, 4'd8,  1'b0, 1'b0, 5'd0};
    tbl[5] = '{16'h0120, 1'b0, 4'd5,  1'b1, 1'b0, 5'd1};
    tbl[6] = '{16'h4000, 1'b1, 4'd14, 1'b1, 1'b0, 5'd0};
    tbl[7] = '{16'h0024, 1'b1, 4'd5,  1'b0, 1'b0, 5'd0};
    tbl[8] = '{16'h0024, 1'b0, 4'd2,  1'b1, 1'b0, 5'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd0);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst out_idx",   32'(out_idx),   32'd0);
    chk("rst out_last",  32'(out_last),  32'd0);
    chk("rst out_zero",  32'(out_zero),  32'd0);
    chk("rst out_cnt",   32'(out_cnt),   32'd0);
    chk("rst stat_words", stat_words, 32'd0);
    chk("rst stat_beats", stat_beats, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle in_ready", 32'(in_ready), 32'd1);
    chk("idle out_valid", 32'(out_valid), 32'd0);

    // Beat table, out_ready held high.
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].new_word) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = tbl[i].data;
        #1;
        chk("tbl accept in_ready", 32'(in_ready), 32'd1);
        chk("tbl accept out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        exp_words++;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
      #1;
      chk_beat("tbl", tbl[i].idx, tbl[i].last, tbl[i].zero, tbl[i].cnt);
      chk("tbl in_ready", 32'(in_ready), 32'(tbl[i].last));
      if (!tbl[i].zero) exp_beats++;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("tbl end out_valid", 32'(out_valid), 32'd0);
    chk("tbl end busy", 32'(busy), 32'd0);
`ifdef BIT_SKIP_SCHED_STAT_EN
    chk("stat_words", stat_words, 32'(exp_words));
    chk("stat_beats", stat_beats, 32'(exp_beats));
`else
    chk("stat_words tied", stat_words, 32'd0);
    chk("stat_beats tied", stat_beats, 32'd0);
`endif

    // 0xFFFF with every beat stalled one cycle first.
    in_valid = 1'b1; in_data = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      out_ready = 1'b0;
      #1;
      chk_beat("ffff", 4'(15 - k), (k == 15), 1'b0, 5'(k));
      chk("ffff stall in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk_beat("ffff hold", 4'(15 - k), (k == 15), 1'b0, 5'(k));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("ffff done out_valid", 32'(out_valid), 32'd0);

    // Back-to-back one-hot words with in_valid held.
    in_valid = 1'b1; in_data = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    in_data = 16'h8000;
    #1;
    chk_beat("b2b w0", 4'd0, 1'b1, 1'b0, 5'd0);
    chk("b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_beat("b2b w1", 4'd15, 1'b1, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("b2b idle busy", 32'(busy), 32'd0);

    // LSB-first instance.
    l_in_valid = 1'b1; l_in_data = 16'h0120;
    @(posedge clk);
    @(negedge clk);
    l_in_valid = 1'b0;
    #1;
    chk("lsb b0 valid", 32'(l_out_valid), 32'd1);
    chk("lsb b0 idx",   32'(l_out_idx),   32'd5);
    chk("lsb b0 last",  32'(l_out_last),  32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("lsb b1 idx",  32'(l_out_idx),  32'd8);
    chk("lsb b1 last", 32'(l_out_last), 32'd1);
    chk("lsb b1 cnt",  32'(l_out_cnt),  32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("lsb done valid", 32'(l_out_valid), 32'd0);

    // Reset during the second beat of 0x00F0.
    in_valid = 1'b1; in_data = 16'h00F0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_beat("rstmid b1", 4'd6, 1'b0, 1'b0, 5'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid out_valid", 32'(out_valid), 32'd0);
    chk("rstmid busy",      32'(busy),      32'd0);
    chk("rstmid in_ready",  32'(in_ready),  32'd0);
    chk("rstmid out_last",  32'(out_last),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post rst in_ready", 32'(in_ready), 32'd1);
    chk("post rst busy",     32'(busy),     32'd0);
    in_valid = 1'b1; in_data = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_beat("post rst", 4'd1, 1'b1, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post rst done", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
